// File: rtl/pipe_ifid_queue.sv
// pipe_ifid_queue
//   Decoupling queue between the IF and ID stages of the pipelined CPU. It
//   replaces a bare IF/ID register. Up to DEPTH fetched {inst, pc4} pairs are
//   buffered so that stalls on the ID side do not lose fetched instructions.
//   A redirect (flush) or reset empties the queue on the next rising edge.
//
//   Optional feature: define IFID_BYPASS_EN to let an instruction pass
//   straight from IF to ID in the same cycle when the queue is empty.
//
// Ports
//   clock     in   pipeline clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset (same effect as flush)
//   if_valid  in   IF presents a fetched instruction
//   if_inst   in   fetched instruction
//   if_pc4    in   PC+4 of the fetched instruction
//   flush     in   redirect taken; discard all contents
//   id_ready  in   ID accepts the head entry this cycle
//   id_valid  out  head entry valid
//   id_inst   out  head instruction, 0 (NOP) when not valid
//   id_pc4    out  head PC+4, 0 when not valid
//   wpcir     out  PC write enable, 1 = IF may advance (queue not full)
//   fq_count  out  current occupancy, 0..DEPTH
module pipe_ifid_queue #(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [31:0]   if_inst,
  input  logic [31:0]   if_pc4,
  input  logic          flush,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   id_inst,
  output logic [31:0]   id_pc4,
  output logic          wpcir,
  output logic [AW:0]   fq_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

`ifdef IFID_BYPASS_EN
  // Bypass presents the IF instruction directly while the queue is empty.
  // If ID takes it in that same cycle it is never written into storage.
  logic bypass;
  assign bypass = empty & if_valid & ~flush & ~reset;
  assign push   = if_valid & ~full & ~flush & ~(bypass & id_ready);
`else
  assign push   = if_valid & ~full & ~flush;
`endif

  // Pops only ever drain storage; id_ready while empty is ignored.
  assign pop = ~empty & id_ready & ~flush;

  assign wpcir    = ~full;
  assign fq_count = count;

  always_comb begin
    id_valid = ~empty;
    id_inst  = '0;
    id_pc4   = '0;
    if (!empty) begin
      {id_inst, id_pc4} = mem[rd_ptr];
    end
`ifdef IFID_BYPASS_EN
    if (bypass) begin
      id_valid = 1'b1;
      id_inst  = if_inst;
      id_pc4   = if_pc4;
    end
`endif
  end

  // Storage is deliberately not cleared by reset or flush; the pointers and
  // count alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= {if_inst, if_pc4};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ifid_queue.sv
// tb_pipe_ifid_queue
//   Self-checking bench for pipe_ifid_queue. A queue-based reference model
//   predicts every output each cycle; directed sequences cover reset, fill,
//   drain/wrap, simultaneous push/pop, flush and bypass, followed by random
//   traffic. Honour IFID_BYPASS_EN the same way the design does.
module tb_pipe_ifid_queue;

  localparam int DEPTH = 2;
  localparam int AW    = $clog2(DEPTH);
`ifdef IFID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        wpcir;
  logic [AW:0] fq_count;

  int unsigned n_vectors    = 0;
  int unsigned n_miscompare = 0;

  logic [63:0] model_q [$];

  pipe_ifid_queue #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_pc4   (if_pc4),
    .flush    (flush),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_inst  (id_inst),
    .id_pc4   (id_pc4),
    .wpcir    (wpcir),
    .fq_count (fq_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One pipeline cycle: drive inputs after the falling edge, check the
  // outputs the model predicts, then advance the model at the rising edge.
  task automatic step(input bit rst, input bit iv, input logic [31:0] inst,
                      input logic [31:0] pc4, input bit fl, input bit rdy,
                      input bit do_check);
    bit          byp;
    bit          exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc4;
    bit          do_pop;
    bit          do_push;
    @(negedge clock);
    reset    = rst;
    if_valid = iv;
    if_inst  = inst;
    if_pc4   = pc4;
    flush    = fl;
    id_ready = rdy;
    #1;
    byp       = BYP && !rst && !fl && iv && (model_q.size() == 0);
    exp_valid = (model_q.size() != 0) || byp;
    exp_inst  = '0;
    exp_pc4   = '0;
    if (model_q.size() != 0) begin
      exp_inst = model_q[0][63:32];
      exp_pc4  = model_q[0][31:0];
    end else if (byp) begin
      exp_inst = inst;
      exp_pc4  = pc4;
    end
    if (do_check) begin
      check_eq("id_valid", 64'(id_valid), 64'(exp_valid));
      check_eq("id_inst",  64'(id_inst),  64'(exp_inst));
      check_eq("id_pc4",   64'(id_pc4),   64'(exp_pc4));
      check_eq("wpcir",    64'(wpcir),    64'(model_q.size() != DEPTH));
      check_eq("fq_count", 64'(fq_count), 64'(model_q.size()));
    end
    @(posedge clock);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && rdy;
      do_push = iv && (model_q.size() < DEPTH) && !(byp && rdy);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({inst, pc4});
    end
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc4 = '0;
    flush = 1'b0; id_ready = 1'b0;

    // Reset held two cycles with if_valid high; first cycle state is unknown.
    step(1, 1, 32'hDEADBEEF, 32'd100, 0, 0, 0);
    step(1, 1, 32'hDEADBEEF, 32'd100, 0, 0, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 1);

    // Fill, then a refused third push; head must stay on the first entry.
    step(0, 1, 32'h20080005, 32'd4,  0, 0, 1);
    step(0, 1, 32'h20090003, 32'd8,  0, 0, 1);
    step(0, 1, 32'h01095020, 32'd12, 0, 0, 1);
    check_eq("full_head_inst", 64'(id_inst), 64'h20080005);

    // Drain while IF keeps retrying 12 then 16; pointers wrap.
    step(0, 1, 32'h01095020, 32'd12, 0, 1, 1);
    step(0, 1, 32'h01095020, 32'd12, 0, 1, 1);
    step(0, 1, 32'hAC0A0004, 32'd16, 0, 1, 1);
    step(0, 0, 32'h0,        32'd0,  0, 1, 1);
    step(0, 0, 32'h0,        32'd0,  0, 1, 1);
    check_eq("drained_count", 64'(fq_count), 64'd0);

    // Simultaneous push and pop at count 1.
    step(0, 1, 32'h11111111, 32'd20, 0, 0, 1);
    step(0, 1, 32'h22222222, 32'd24, 0, 1, 1);
    step(0, 0, 32'h0,        32'd0,  0, 0, 1);
    check_eq("pushpop_head", 64'(id_pc4), 64'd24);

    // Flush at count 2 drops everything including the same-cycle fetch.
    step(0, 1, 32'h33333333, 32'd28, 0, 0, 1);
    step(0, 1, 32'h44444444, 32'd32, 1, 1, 1);
    step(0, 0, 32'h0,        32'd0,  0, 0, 1);
    check_eq("flush_valid", 64'(id_valid), 64'd0);

    // Empty queue, fetch with ID ready: bypass or one-cycle latency.
    step(0, 1, 32'h8C0B0000, 32'd36, 0, 1, 1);
    step(0, 0, 32'h0,        32'd0,  0, 1, 1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, $urandom,
           $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
    $finish;
  end

endmodule
